gsc_pulse_gen: RTL and testbench
================================

// Module: gsc_pulse_gen
// PURPOSE
//  Programmable square-wave/burst generator driving the gsc "gen" pin; consumer of decoded SPI words.
//  Sits downstream of the SPI 16-bit receiver: takes {address, word, strobe} in clk domain, holds
//  register bank, divides clk to produce gen. Replaces fixed gen logic; counter/seg7 path untouched.
// PARAMETERS
//  CW          16      width of divider counter and registers
//  HALF_RST    16'd1   reset value of HALF register (gen half-period in clk cycles)
//  SYNC_STAGES 2       flops in ext_sync synchronizer (only with GSC_PULSE_SYNC_EN)
// PORTS
//  clk        in   1   system clock (24 MHz)
//  reset_n    in   1   asynchronous active-low reset
//  wr_stb     in   1   one-cycle write strobe from SPI receiver, clk domain
//  wr_addr    in   2   register address (spi_a captured with the word)
//  wr_data    in   CW  received 16-bit word
//  ext_sync   in   1   async phase-restart input (present only with GSC_PULSE_SYNC_EN)
//  gen        out  1   generator output, registered
//  busy       out  1   1 while generator running (CTRL.RUN set)
//  done       out  1   one-cycle pulse when a burst completes
// BEHAVIOUR
//  Registers (write-only, written on wr_stb, visible next cycle):
//   0 HALF  half-period N; effective half-period = max(N,1) clk cycles
//   1 CTRL  [0] RUN, [12] BURST mode; other bits ignored
//   2 BCNT  burst length in gen rising edges
//   3 reserved, writes ignored
//  Reset: HALF=HALF_RST, CTRL=0, BCNT=0, div cnt=0, edge cnt=0, gen=0, busy=0, done=0.
//  States: IDLE (RUN=0), RUN_FREE (RUN=1,BURST=0), RUN_BURST (RUN=1,BURST=1).
//  IDLE: gen=0, counters held at 0. Write CTRL.RUN=1 -> run state next cycle; first gen rise after
//   max(N,1) cycles from CTRL write.
//  Running: div cnt increments each clk; at cnt==max(N,1)-1 gen toggles, cnt<=0.
//  HALF write while running: taken at next toggle boundary only (shadow reg), no runt pulse.
//  RUN_BURST: each gen 0->1 increments edge cnt; when edge cnt==BCNT and gen returns 0: RUN<=0,
//   done=1 for one cycle, -> IDLE. BCNT=0 with BURST: no pulses, done next cycle, RUN cleared.
//  CTRL write with RUN=0 while running: gen<=0, counters cleared next cycle, no done pulse.
//  CTRL rewrite with RUN=1 while running: restarts phase (cnt=0, gen=0, edge cnt=0).
//  Counter wrap: cnt never exceeds CW bits; N=16'hFFFF -> half-period 65535 cycles.
//  Async reset mid-run: all state to reset values immediately; gen low without waiting for clk.
//  busy = CTRL.RUN registered value.
// CONFIGURATION
//  GSC_PULSE_SYNC_EN defined: ext_sync port exists; SYNC_STAGES-flop synchronizer + rising-edge
//   detect; detected edge while running forces cnt=0, gen=0 (edge cnt kept), 1 cycle after sync
//   output rises. Edge coinciding with toggle: restart wins.
//  Not defined: no ext_sync port, no synchronizer logic; behaviour otherwise identical.
// STRUCTURE
//  Shared include gsc_defs.vh: `define for register addresses (GSC_A_HALF=0, GSC_A_CTRL=1,
//   GSC_A_BCNT=2), CTRL bit indices (GSC_CTRL_RUN=0, GSC_CTRL_BURST=12), state encodings.
//  One sub-module: gsc_sync_edge (N-flop synchronizer + rising-edge pulse), instantiated only under
//   GSC_PULSE_SYNC_EN; reusable for counter_in path.
// TESTING
//  1 reset held 200 ns -> gen=0, busy=0, done=0; after release no toggles for 10 us.
//  2 write HALF=0x0002 then CTRL=0x0001 -> busy=1, gen period 4 clk (168 ns), 50% duty.
//  3 HALF=0x0004, CTRL=0x1001, BCNT=0x0003 -> exactly 3 gen pulses of 4 clk high, done pulse
//    1 cycle, busy=0, gen stays 0.
//  4 running at HALF=2, write HALF=0 -> half-period becomes 1 clk from next toggle, no <1-clk pulse.
//  5 reset_n low mid-burst -> gen=0 asynchronously; after release state as scenario 1, no done.
//  6 (GSC_PULSE_SYNC_EN) HALF=8 running, pulse ext_sync -> gen=0 and cnt=0 within SYNC_STAGES+1
//    clk; next rise 8 clk later; BCNT=0 with BURST -> done next cycle, zero pulses.

Source files
------------

// File: rtl/gsc_pulse_gen_pkg.sv
// Shared register map, CTRL bit positions and FSM state encoding for the gsc pulse generator.
package gsc_pulse_gen_pkg;

    localparam logic [1:0] GSC_A_HALF = 2'd0;
    localparam logic [1:0] GSC_A_CTRL = 2'd1;
    localparam logic [1:0] GSC_A_BCNT = 2'd2;

    localparam int GSC_CTRL_RUN   = 0;
    localparam int GSC_CTRL_BURST = 12;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN_FREE  = 2'd1,
        ST_RUN_BURST = 2'd2
    } gscState_e;

endpackage

// File: rtl/gsc_sync_edge.sv
// N-flop synchronizer with a rising-edge pulse on the synchronized output.
// Compiled only when GSC_PULSE_SYNC_EN is defined (its sole user is the ext_sync path).
`ifdef GSC_PULSE_SYNC_EN
module gsc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              syncOut;

    assign syncOut = chain_q[STAGES-1];
    assign rise_o  = syncOut & ~prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
            prev_q  <= syncOut;
        end
    end

endmodule
`endif

// File: rtl/gsc_pulse_gen.sv
// Programmable square-wave / burst generator for the gsc "gen" pin, fed by decoded SPI writes.
// Optional GSC_PULSE_SYNC_EN adds the ext_sync phase-restart input and its synchronizer.
module gsc_pulse_gen
    import gsc_pulse_gen_pkg::*;
#(
    parameter int            CW       = 16,
    parameter logic [CW-1:0] HALF_RST = CW'(1)
`ifdef GSC_PULSE_SYNC_EN
    ,
    parameter int            SYNC_STAGES = 2
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_stb,
    input  logic [1:0]    wr_addr,
    input  logic [CW-1:0] wr_data,
`ifdef GSC_PULSE_SYNC_EN
    input  logic          ext_sync,
`endif
    output logic          gen,
    output logic          busy,
    output logic          done
);

    gscState_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] edgeCnt_q, edgeCnt_d;
    logic [CW-1:0] halfReg_q, halfReg_d;
    logic [CW-1:0] halfAct_q, halfAct_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          gen_q, gen_d;
    logic          done_q, done_d;
    logic [CW-1:0] termCnt;
    logic          ctrlWr;
    logic          syncRise;

`ifdef GSC_PULSE_SYNC_EN
    gsc_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (ext_sync),
        .rise_o  (syncRise)
    );
`else
    assign syncRise = 1'b0;
`endif

    // halfAct_q is the shadow copy in use; HALF writes only reach it at a toggle boundary.
    assign termCnt = (halfAct_q == '0) ? '0 : halfAct_q - 1'b1;
    assign ctrlWr  = wr_stb && (wr_addr == GSC_A_CTRL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edgeCnt_q <= '0;
            halfReg_q <= HALF_RST;
            halfAct_q <= HALF_RST;
            bcnt_q    <= '0;
            gen_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edgeCnt_q <= edgeCnt_d;
            halfReg_q <= halfReg_d;
            halfAct_q <= halfAct_d;
            bcnt_q    <= bcnt_d;
            gen_q     <= gen_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edgeCnt_d = edgeCnt_q;
        halfReg_d = halfReg_q;
        halfAct_d = halfAct_q;
        bcnt_d    = bcnt_q;
        gen_d     = gen_q;
        done_d    = 1'b0;

        if (wr_stb && (wr_addr == GSC_A_HALF)) halfReg_d = wr_data;
        if (wr_stb && (wr_addr == GSC_A_BCNT)) bcnt_d = wr_data;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                edgeCnt_d = '0;
                gen_d     = 1'b0;
                halfAct_d = halfReg_q;
            end
            ST_RUN_FREE, ST_RUN_BURST: begin
                if (syncRise) begin
                    cnt_d     = '0;
                    gen_d     = 1'b0;
                    halfAct_d = halfReg_q;
                end else if (cnt_q == termCnt) begin
                    cnt_d     = '0;
                    gen_d     = ~gen_q;
                    halfAct_d = halfReg_q;
                    if (!gen_q) begin
                        edgeCnt_d = edgeCnt_q + 1'b1;
                    end else if ((state_q == ST_RUN_BURST) && (edgeCnt_q >= bcnt_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any CTRL write restarts the phase; an empty burst completes without ever running.
        if (ctrlWr) begin
            cnt_d     = '0;
            edgeCnt_d = '0;
            gen_d     = 1'b0;
            halfAct_d = halfReg_q;
            done_d    = 1'b0;
            if (!wr_data[GSC_CTRL_RUN]) begin
                state_d = ST_IDLE;
            end else if (wr_data[GSC_CTRL_BURST]) begin
                if (bcnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN_BURST;
                end
            end else begin
                state_d = ST_RUN_FREE;
            end
        end
    end

    assign gen  = gen_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_gsc_pulse_gen.sv
// Directed self-checking bench for gsc_pulse_gen; the ext_sync section runs only with GSC_PULSE_SYNC_EN.
module tb_gsc_pulse_gen;
    import gsc_pulse_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        gen;
    logic        busy;
    logic        done;
`ifdef GSC_PULSE_SYNC_EN
    logic        ext_sync;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   highSeen;
    int   doneSeen;
    logic expGen;

    gsc_pulse_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef GSC_PULSE_SYNC_EN
        .ext_sync(ext_sync),
`endif
        .gen     (gen),
        .busy    (busy),
        .done    (done)
    );

    always #21 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the write is sampled by the following rising edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
        wr_addr = addr;
        wr_data = data;
        wr_stb  = 1'b1;
        @(negedge clk);
        wr_stb  = 1'b0;
        wr_addr = 2'd0;
        wr_data = 16'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_stb  = 1'b0;
        wr_addr = 2'd0;
        wr_data = 16'd0;
`ifdef GSC_PULSE_SYNC_EN
        ext_sync = 1'b0;
`endif

        #200;
        checkOutput("rst_gen", gen, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        highSeen = 0;
        repeat (240) begin
            @(negedge clk);
            if (gen) highSeen++;
        end
        checkOutput("idle_no_toggle", highSeen, 0);
        checkOutput("idle_busy", busy, 0);

        // Free run at HALF=2: period of 4 clocks, 50% duty.
        applyStimulus(GSC_A_HALF, 16'h0002);
        applyStimulus(GSC_A_CTRL, 16'h0001);
        checkOutput("free_busy", busy, 1);
        checkOutput("free_gen0", gen, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("free_gen_%0d", k), gen, (k / 2) % 2);
        end

        // HALF=0 while running: old half-period finishes, then 1-clock halves.
        applyStimulus(GSC_A_HALF, 16'h0000);
        checkOutput("half0_gen_0", gen, 0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            checkOutput($sformatf("half0_gen_%0d", j), gen, j % 2);
        end

        // CTRL rewrite with RUN=1 restarts the phase at the new HALF=3.
        applyStimulus(GSC_A_HALF, 16'h0003);
        applyStimulus(GSC_A_CTRL, 16'h0001);
        checkOutput("restart_gen_0", gen, 0);
        checkOutput("restart_busy", busy, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            expGen = (k >= 3) && (k < 6);
            checkOutput($sformatf("restart_gen_%0d", k), gen, expGen);
        end
        applyStimulus(GSC_A_CTRL, 16'h0000);
        checkOutput("stop_gen", gen, 0);
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_done", done, 0);

        // Burst of 3 pulses at HALF=4, done on the last falling edge.
        applyStimulus(GSC_A_HALF, 16'h0004);
        applyStimulus(GSC_A_BCNT, 16'h0003);
        applyStimulus(GSC_A_CTRL, 16'h1001);
        checkOutput("burst_busy_0", busy, 1);
        checkOutput("burst_gen_0", gen, 0);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            expGen = (k >= 4) && (k < 24) && (((k - 4) % 8) < 4);
            checkOutput($sformatf("burst_gen_%0d", k), gen, expGen);
            checkOutput($sformatf("burst_busy_%0d", k), busy, k < 24);
            checkOutput($sformatf("burst_done_%0d", k), done, k == 24);
        end

        // Asynchronous reset in the middle of a burst.
        applyStimulus(GSC_A_CTRL, 16'h1001);
        repeat (5) @(negedge clk);
        checkOutput("midburst_gen_high", gen, 1);
        #5;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_gen", gen, 0);
        checkOutput("async_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        highSeen = 0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (gen) highSeen++;
            if (done) doneSeen++;
        end
        checkOutput("post_rst_no_gen", highSeen, 0);
        checkOutput("post_rst_no_done", doneSeen, 0);

        // HALF back at its reset value of 1: gen toggles every clock.
        applyStimulus(GSC_A_CTRL, 16'h0001);
        checkOutput("halfrst_gen_0", gen, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("halfrst_gen_%0d", k), gen, k % 2);
        end
        applyStimulus(GSC_A_CTRL, 16'h0000);
        checkOutput("halfrst_stop_busy", busy, 0);

        // Burst with BCNT=0 (reset value): immediate done, no pulses.
        applyStimulus(GSC_A_CTRL, 16'h1001);
        checkOutput("bcnt0_done", done, 1);
        checkOutput("bcnt0_busy", busy, 0);
        checkOutput("bcnt0_gen", gen, 0);
        @(negedge clk);
        checkOutput("bcnt0_done_clear", done, 0);
        highSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (gen || busy) highSeen++;
        end
        checkOutput("bcnt0_no_pulses", highSeen, 0);

`ifdef GSC_PULSE_SYNC_EN
        applyStimulus(GSC_A_HALF, 16'h0008);
        applyStimulus(GSC_A_CTRL, 16'h0001);
        repeat (10) @(negedge clk);
        checkOutput("sync_pre_gen", gen, 1);
        ext_sync = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("sync_wait_gen", gen, 1);
        @(negedge clk);
        checkOutput("sync_restart_gen", gen, 0);
        repeat (7) @(negedge clk);
        checkOutput("sync_low_gen", gen, 0);
        @(negedge clk);
        checkOutput("sync_rise_gen", gen, 1);
        ext_sync = 1'b0;
        applyStimulus(GSC_A_CTRL, 16'h0000);
        checkOutput("sync_stop_busy", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
